// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream program loader that assembles little-endian words into the instruction memory.
// Optional trailing XOR checksum byte enabled with `define LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Start,
    input  logic        i_Valid,
    input  logic [7:0]  i_Byte,
    output logic        o_Ready,
    output logic        o_MemWrite,
    output logic [31:0] o_Address,
    output logic [31:0] o_WriteData,
    output logic        o_CpuHold,
    output logic        o_Done,
    output logic        o_Error
);

    localparam int unsigned IDX_W = 8;
    localparam logic [IDX_W-1:0] DEPTH_N = IDX_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] widx_q;
    logic [IDX_W-1:0] addr_idx_q;
    logic [1:0]       bidx_q;
    logic [31:0]      word_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    logic accept;

    // Outputs are pure decodes of registered state; no path from i_Valid to o_Ready.
    assign o_Ready     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    assign o_MemWrite  = (state_q == S_WRITE);
    assign o_Done      = (state_q == S_DONE);
    assign o_Error     = (state_q == S_ERROR);
    assign o_CpuHold   = (state_q != S_IDLE);
    assign o_Address   = {22'b0, addr_idx_q, 2'b00};
    assign o_WriteData = word_q;

    assign accept = i_Valid & o_Ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            widx_q     <= '0;
            addr_idx_q <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (i_Start) begin
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        cnt_q  <= i_Byte;
                        widx_q <= '0;
                        bidx_q <= '0;
                        word_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        chk_q  <= i_Byte;
`endif
                        if ((i_Byte == 8'd0) || (i_Byte > DEPTH_N)) begin
                            state_q <= S_ERROR;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_q[{bidx_q, 3'b000} +: 8] <= i_Byte;
                        bidx_q                        <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_q                         <= chk_q ^ i_Byte;
`endif
                        // Snapshot the address so it never shows the post-increment index.
                        if (bidx_q == 2'd3) begin
                            addr_idx_q <= widx_q;
                            state_q    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    widx_q <= widx_q + 8'd1;
                    if ((widx_q + 8'd1) == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
`else
                        state_q <= S_DONE;
`endif
                    end else begin
                        state_q <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        state_q <= (i_Byte == chk_q) ? S_DONE : S_ERROR;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
